// File: rtl/det_pkg.sv
// Shared types and widths for the detection cascade sequencer.
// Imported by the scan counter, the datapath interface and the controller.
package det_pkg;

  localparam int OM_AW       = 13;
  localparam int DEF_STAGES  = 4;
  localparam int DEF_TIMEOUT = 4096;
  localparam int STAGE_W     = $clog2(DEF_STAGES);
  localparam int TO_W        = $clog2(DEF_TIMEOUT);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_GEN    = 3'd2;
  localparam logic [2:0] ST_CLASS  = 3'd3;
  localparam logic [2:0] ST_DECIDE = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    GEN    = ST_GEN,
    CLASS  = ST_CLASS,
    DECIDE = ST_DECIDE,
    NEXT   = ST_NEXT,
    DONE   = ST_DONE
  } state_t;

  function automatic logic [OM_AW-1:0] satInc(
    input logic [OM_AW-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/detection_ctrl_if.sv
// Strobe/status bundle between the cascade sequencer and the
// HFG / feature BRAM / ANN detection datapath.
interface detection_ctrl_if;
  import det_pkg::*;

  logic             oReady_HFG;
  logic             oRun_HFG;
  logic             oRun_ANN;
  logic [OM_AW-1:0] oAddr_OM;
  logic             iFull;
  logic             iFull_FBR;
  logic             iFinish;
  logic             iFinish_Stage;
  logic             iPass;

  modport master (
    output oReady_HFG, oRun_HFG, oRun_ANN, oAddr_OM,
    input  iFull, iFull_FBR, iFinish, iFinish_Stage, iPass
  );

  modport slave (
    input  oReady_HFG, oRun_HFG, oRun_ANN, oAddr_OM,
    output iFull, iFull_FBR, iFinish, iFinish_Stage, iPass
  );

endinterface

// File: rtl/win_scan_cnt.sv
// Window raster scan: x/y position and linear output-memory address.
// The address is a plain incrementer so no multiplier is needed.
module win_scan_cnt
  import det_pkg::*;
#(
  parameter int WIN_COLS = 64,
  parameter int WIN_ROWS = 48
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iClear,
  input  logic             iAdvance,
  output logic [OM_AW-1:0] oAddr,
  output logic             oLast
);

  localparam int XW = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;
  localparam int YW = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          xEnd;

  assign xEnd  = (x == XW'(WIN_COLS - 1));
  assign oLast = xEnd && (y == YW'(WIN_ROWS - 1));

  always_ff @(posedge iClk) begin
    if (!iReset_n || iClear) begin
      x     <= '0;
      y     <= '0;
      oAddr <= '0;
    end else if (iAdvance) begin
      oAddr <= oAddr + 1'b1;
      if (xEnd) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/detection_ctrl.sv
// Cascade sequencer: scans every window of a frame and steps each one
// through the classifier stages, rejecting early and guarding timeouts.
module detection_ctrl
  import det_pkg::*;
#(
  parameter int WIN_COLS    = 64,
  parameter int WIN_ROWS    = 48,
  parameter int NUM_STAGES  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iStart,
  detection_ctrl_if.master dp,
  output logic [OM_AW-1:0] oFace_cnt,
  output logic             oBusy,
  output logic             oDone,
  output logic             oError
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t        st;
  logic [SW-1:0] stage;
  logic [TW-1:0] toCnt;
  logic          passQ;
  logic          toHit;
  logic          lastStage;
  logic          scanLast;
  logic          scanClr;
  logic          scanAdv;

  assign toHit     = (toCnt == TW'(TIMEOUT_CYC - 1));
  assign lastStage = (stage == SW'(NUM_STAGES - 1));
  assign scanClr   = (st == IDLE);
  assign scanAdv   = (st == NEXT) && !scanLast;

  win_scan_cnt #(
    .WIN_COLS (WIN_COLS),
    .WIN_ROWS (WIN_ROWS)
  ) u_scan (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .iClear   (scanClr),
    .iAdvance (scanAdv),
    .oAddr    (dp.oAddr_OM),
    .oLast    (scanLast)
  );

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      st            <= IDLE;
      stage         <= '0;
      toCnt         <= '0;
      passQ         <= 1'b0;
      dp.oReady_HFG <= 1'b0;
      dp.oRun_HFG   <= 1'b0;
      dp.oRun_ANN   <= 1'b0;
      oFace_cnt     <= '0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oError        <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          stage <= '0;
          if (iStart) begin
            st            <= LOAD;
            dp.oReady_HFG <= 1'b1;
            oBusy         <= 1'b1;
            oFace_cnt     <= '0;
            oError        <= 1'b0;
          end
        end
        LOAD: begin
          if (dp.iFull) begin
            st            <= GEN;
            dp.oReady_HFG <= 1'b0;
            dp.oRun_HFG   <= 1'b1;
            stage         <= '0;
            toCnt         <= '0;
          end
        end
        GEN: begin
          if (dp.iFull_FBR || dp.iFinish) begin
            st          <= CLASS;
            dp.oRun_HFG <= 1'b0;
            dp.oRun_ANN <= 1'b1;
            toCnt       <= '0;
          end else if (toHit) begin
            st          <= NEXT;
            dp.oRun_HFG <= 1'b0;
            oError      <= 1'b1;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        CLASS: begin
          if (dp.iFinish_Stage) begin
            st          <= DECIDE;
            dp.oRun_ANN <= 1'b0;
            passQ       <= dp.iPass;
          end else if (toHit) begin
            st          <= NEXT;
            dp.oRun_ANN <= 1'b0;
            oError      <= 1'b1;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        DECIDE: begin
          if (passQ && !lastStage) begin
            st          <= GEN;
            stage       <= stage + 1'b1;
            dp.oRun_HFG <= 1'b1;
            toCnt       <= '0;
          end else begin
            st <= NEXT;
            if (passQ) oFace_cnt <= satInc(oFace_cnt);
          end
        end
        NEXT: begin
          if (scanLast) begin
            st    <= DONE;
            oDone <= 1'b1;
          end else begin
            st            <= LOAD;
            dp.oReady_HFG <= 1'b1;
          end
        end
        DONE: begin
          st    <= IDLE;
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
